// File: rtl/credit_pkg.sv
// Shared types for the credit/start sequencing helpers.
package credit_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COIN    = 3'd1,
        GAP     = 3'd2,
        START   = 3'd3,
        RELEASE = 3'd4
    } seq_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    // Coins inserted before the start pulse for each player.
    localparam logic [1:0] P1_COINS = 2'd1;
    localparam logic [1:0] P2_COINS = 2'd2;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the core's vblank level into a one-cycle frame tick, registered,
// so frame-timed helpers can count frames instead of clocks.
module frame_tick_gen (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic vblank_i,
    output logic tick_o
);

    logic vblank_q;
    logic tick_q;

    // Rising-edge detect of vblank; the tick appears one cycle after 0->1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            vblank_q <= vblank_i;
            tick_q   <= vblank_i & ~vblank_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/credit_sequencer.sv
// Converts player start requests into coin pulse(s) followed by a start
// pulse, all timed in video frames. Player 2 gets two coins, player 1 one.
// hold freezes the sequencer in IDLE with all outputs low.
module credit_sequencer
    import credit_pkg::*;
#(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 4,
    parameter int START_FRAMES = 4,
    parameter int CNT_W        = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic hold,
    input  logic vblank,
    input  logic req_start1,
    input  logic req_start2,
    input  logic coin_in,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
);

    localparam int MAX_FRAMES = (1 << CNT_W) - 1;

    if (COIN_FRAMES < 1 || COIN_FRAMES > MAX_FRAMES ||
        GAP_FRAMES < 1 || GAP_FRAMES > MAX_FRAMES ||
        START_FRAMES < 1 || START_FRAMES > MAX_FRAMES) begin : g_bad_params
        $error("credit_sequencer: frame counts must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_FRAMES - 1);

    logic             frame_tick;
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       coins_q, coins_d;
    player_t          sel_q, sel_d;
    logic             req1_q, req2_q;
    logic             rise1, rise2;
    logic [CNT_W-1:0] last_cnt;
    logic             phase_done;
    logic             coin_out_q, start1_q, start2_q, busy_q;

    frame_tick_gen u_tick (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vblank_i(vblank),
        .tick_o  (frame_tick)
    );

    assign rise1 = req_start1 & ~req1_q;
    assign rise2 = req_start2 & ~req2_q;

    // Terminal count of the current timed phase; a phase ends on the tick
    // that would take the counter to N.
    always_comb begin
        last_cnt = '0;
        case (state_q)
            COIN:    last_cnt = COIN_LAST;
            GAP:     last_cnt = GAP_LAST;
            START:   last_cnt = START_LAST;
            default: last_cnt = '0;
        endcase
    end

    assign phase_done = frame_tick & (cnt_q == last_cnt);

    // Next-state, coin bookkeeping and frame counter.
    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (rise2) begin
                    state_d = COIN;
                    coins_d = P2_COINS;
                    sel_d   = P2;
                end else if (rise1) begin
                    state_d = COIN;
                    coins_d = P1_COINS;
                    sel_d   = P1;
                end
            end
            COIN: begin
                if (phase_done) begin
                    state_d = GAP;
                    coins_d = coins_q - 2'd1;
                end
            end
            GAP: begin
                if (phase_done) begin
                    state_d = (coins_q != 2'd0) ? COIN : START;
                end
            end
            START: begin
                if (phase_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for both buttons up so a held button cannot re-trigger.
                if (!req_start1 && !req_start2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hold) begin
            state_d = IDLE;
            coins_d = 2'd0;
        end

        cnt_d = cnt_q;
        if (hold || state_d != state_q || state_q == IDLE || state_q == RELEASE) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counters and edge history.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coins_q <= 2'd0;
            sel_q   <= P1;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coins_q <= coins_d;
            sel_q   <= sel_d;
            req1_q  <= req_start1;
            req2_q  <= req_start2;
        end
    end

    // Registered outputs; hold forces everything low including the coin passthrough.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_out_q <= 1'b0;
            start1_q   <= 1'b0;
            start2_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            coin_out_q <= ~hold & ((state_q == COIN) | coin_in);
            start1_q   <= ~hold & (state_q == START) & (sel_q == P1);
            start2_q   <= ~hold & (state_q == START) & (sel_q == P2);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign coin_out   = coin_out_q;
    assign start1_out = start1_q;
    assign start2_out = start2_q;
    assign busy       = busy_q;

endmodule
